// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage: counted multiply, 1-bit/cycle
// restoring divider, MTHI/MTLO writes, and the pipeline stall that covers them.
module muldiv_ctrl #(
    parameter int          DATA_W     = 32,
    parameter int          MUL_CYCLES = 2,
    parameter logic [4:0]  OP_MULT    = 5'd16,
    parameter logic [4:0]  OP_MULTU   = 5'd17,
    parameter logic [4:0]  OP_DIV     = 5'd18,
    parameter logic [4:0]  OP_DIVU    = 5'd19,
    parameter logic [4:0]  OP_MTHI    = 5'd20,
    parameter logic [4:0]  OP_MTLO    = 5'd21
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [4:0]        alucontrol,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic              stall_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    // state | meaning
    // IDLE  | waiting for a muldiv op; MTHI/MTLO write here
    // MUL   | counting down the multiply latency
    // DIV   | one restoring-division step per cycle
    // DONE  | result written, stall released so the op leaves EX
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam int CNT_W = $clog2((DATA_W > MUL_CYCLES) ? DATA_W : MUL_CYCLES);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   raw_a;
    logic                mul_signed;
    logic                q_neg;
    logic                r_neg;
    logic                div_zero;

    logic                is_mul;
    logic                is_div;
    logic                div_signed;
    logic [DATA_W-1:0]   a_abs;
    logic [DATA_W-1:0]   b_abs;
    logic [2*DATA_W-1:0] ext_a;
    logic [2*DATA_W-1:0] ext_b;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     diff;
    logic                no_borrow;
    logic [DATA_W-1:0]   next_rem;
    logic [DATA_W-1:0]   next_quo;
    logic [DATA_W-1:0]   q_fix;
    logic [DATA_W-1:0]   r_fix;

    assign is_mul     = (alucontrol == OP_MULT) || (alucontrol == OP_MULTU);
    assign is_div     = (alucontrol == OP_DIV)  || (alucontrol == OP_DIVU);
    assign div_signed = (alucontrol == OP_DIV);

    // Magnitudes; -0x80000000 wraps to itself, which is the right unsigned magnitude.
    assign a_abs = (div_signed && a[DATA_W-1]) ? (~a + 1'b1) : a;
    assign b_abs = (div_signed && b[DATA_W-1]) ? (~b + 1'b1) : b;

    assign ext_a = mul_signed ? {{DATA_W{op_a[DATA_W-1]}}, op_a} : {{DATA_W{1'b0}}, op_a};
    assign ext_b = mul_signed ? {{DATA_W{op_b[DATA_W-1]}}, op_b} : {{DATA_W{1'b0}}, op_b};
    assign prod  = ext_a * ext_b;

    // op_a doubles as the dividend shift register; quotient bits enter at the bottom.
    assign shifted   = {rem, op_a[DATA_W-1]};
    assign diff      = shifted - {1'b0, op_b};
    assign no_borrow = ~diff[DATA_W];
    assign next_rem  = no_borrow ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    assign next_quo  = {op_a[DATA_W-2:0], no_borrow};
    assign q_fix     = q_neg ? (~next_quo + 1'b1) : next_quo;
    assign r_fix     = r_neg ? (~next_rem + 1'b1) : next_rem;

    assign busy_o  = (state != IDLE);
    assign stall_o = resetn & ~flush &
                     (((state == IDLE) & start & (is_mul | is_div)) |
                      (state == MUL) | (state == DIV));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rem        <= '0;
            raw_a      <= '0;
            mul_signed <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            div_zero   <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        if (is_mul) begin
                            op_a       <= a;
                            op_b       <= b;
                            mul_signed <= (alucontrol == OP_MULT);
                            cnt        <= CNT_W'(MUL_CYCLES - 1);
                            state      <= MUL;
                        end else if (is_div) begin
                            op_a     <= a_abs;
                            op_b     <= b_abs;
                            q_neg    <= div_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
                            r_neg    <= div_signed & a[DATA_W-1];
                            div_zero <= (b == '0);
                            raw_a    <= a;
                            rem      <= '0;
                            cnt      <= CNT_W'(DATA_W - 1);
                            state    <= DIV;
                        end else if (alucontrol == OP_MTHI) begin
                            hi_o <= a;
                        end else if (alucontrol == OP_MTLO) begin
                            lo_o <= a;
                        end
                    end
                end
                MUL: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        hi_o  <= prod[2*DATA_W-1:DATA_W];
                        lo_o  <= prod[DATA_W-1:0];
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        op_a <= next_quo;
                        rem  <= next_rem;
                        if (cnt == '0) begin
                            // Divide by zero bypasses the sign fix and reports the raw dividend.
                            if (div_zero) begin
                                lo_o <= '1;
                                hi_o <= raw_a;
                            end else begin
                                lo_o <= q_fix;
                                hi_o <= r_fix;
                            end
                            state <= DONE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed cases with literal results plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_muldiv_ctrl;

    localparam logic [4:0] OP_MULT  = 5'd16;
    localparam logic [4:0] OP_MULTU = 5'd17;
    localparam logic [4:0] OP_DIV   = 5'd18;
    localparam logic [4:0] OP_DIVU  = 5'd19;
    localparam logic [4:0] OP_MTHI  = 5'd20;
    localparam logic [4:0] OP_MTLO  = 5'd21;
    localparam int MULC = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [4:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall_o;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    muldiv_ctrl #(
        .DATA_W(32), .MUL_CYCLES(MULC),
        .OP_MULT(OP_MULT), .OP_MULTU(OP_MULTU), .OP_DIV(OP_DIV),
        .OP_DIVU(OP_DIVU), .OP_MTHI(OP_MTHI), .OP_MTLO(OP_MTLO)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .alucontrol(alucontrol),
        .a(a), .b(b), .flush(flush), .stall_o(stall_o), .busy_o(busy_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int stall_cnt = 0;

    // Reference model: cycles left in the op, whether the release cycle is pending,
    // architectural HI/LO and the result waiting to be committed.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic bit is_md(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic bit model_busy();
        return (m_left > 0) || m_done;
    endfunction

    function automatic void calc(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] hi, output logic [31:0] lo);
        longint      p;
        logic [63:0] u;
        int          q;
        int          r;
        hi = '0;
        lo = '0;
        if (op == OP_MULT) begin
            p  = longint'($signed(x)) * longint'($signed(y));
            hi = p[63:32];
            lo = p[31:0];
        end else if (op == OP_MULTU) begin
            u  = {32'b0, x} * {32'b0, y};
            hi = u[63:32];
            lo = u[31:0];
        end else if (y == 32'd0) begin
            lo = 32'hFFFFFFFF;
            hi = x;
        end else if (op == OP_DIVU) begin
            lo = x / y;
            hi = x % y;
        end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            lo = 32'h80000000;
            hi = 32'd0;
        end else begin
            q  = $signed(x) / $signed(y);
            r  = $signed(x) % $signed(y);
            lo = q;
            hi = r;
        end
    endfunction

    function automatic void model_edge();
        if (flush) begin
            m_left = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi   = p_hi;
                m_lo   = p_lo;
                m_done = 1'b1;
            end
        end else if (start) begin
            if (is_md(alucontrol)) begin
                calc(alucontrol, a, b, p_hi, p_lo);
                m_left = ((alucontrol == OP_MULT) || (alucontrol == OP_MULTU)) ? MULC : 32;
            end else if (alucontrol == OP_MTHI) begin
                m_hi = a;
            end else if (alucontrol == OP_MTLO) begin
                m_lo = a;
            end
        end
    endfunction

    function automatic void check_outputs();
        bit exp_stall;
        exp_stall = resetn && !flush &&
                    ((!model_busy() && start && is_md(alucontrol)) || (m_left > 0));
        check("stall_o", 32'(stall_o), 32'(exp_stall));
        check("busy_o", 32'(busy_o), 32'(model_busy()));
        check("hi_o", hi_o, m_hi);
        check("lo_o", lo_o, m_lo);
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        #1;
        check_outputs();
        if (stall_o) stall_cnt++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        start      = 1'b1;
        alucontrol = op;
        a          = x;
        b          = y;
        flush      = 1'b0;
        stall_cnt  = 0;
        cycle();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        for (int i = 0; i < 100 && model_busy(); i++) cycle();
        if (model_busy()) check("op_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    logic [4:0]  op_pool [8] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, 5'd0, 5'd3};
    logic [31:0] save_hi;
    logic [31:0] save_lo;

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        flush      = 1'b0;
        alucontrol = 5'd0;
        a          = '0;
        b          = '0;
        @(negedge clk);
        #1;
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_stall", 32'(stall_cnt), 32'd3);
        check("multu_hi", hi_o, 32'hFFFFFFFE);
        check("multu_lo", lo_o, 32'h00000001);

        run_op(OP_MULT, 32'hFFFFFFFE, 32'd3);
        check("mult_hi", hi_o, 32'hFFFFFFFF);
        check("mult_lo", lo_o, 32'hFFFFFFFA);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
        check("div_stall", 32'(stall_cnt), 32'd33);
        check("div_lo", lo_o, 32'hFFFFFFFD);
        check("div_hi", hi_o, 32'hFFFFFFFF);

        run_op(OP_DIVU, 32'd100, 32'd7);
        check("divu_lo", lo_o, 32'd14);
        check("divu_hi", hi_o, 32'd2);

        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        check("ovf_lo", lo_o, 32'h80000000);
        check("ovf_hi", hi_o, 32'd0);

        run_op(OP_DIVU, 32'd5, 32'd0);
        check("dz_stall", 32'(stall_cnt), 32'd33);
        check("dz_lo", lo_o, 32'hFFFFFFFF);
        check("dz_hi", hi_o, 32'd5);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'd0);
        check("dzs_hi", hi_o, 32'hFFFFFFF9);

        // MTHI takes effect at the accept edge with no stall.
        stall_cnt  = 0;
        start      = 1'b1;
        alucontrol = OP_MTHI;
        a          = 32'h12345678;
        cycle();
        start = 1'b0;
        a     = 32'hDEADBEEF;
        check("mthi_hi", hi_o, 32'h12345678);
        cycle();
        check("mthi_stall", 32'(stall_cnt), 32'd0);

        // Flush in the middle of a divide.
        save_hi    = hi_o;
        save_lo    = lo_o;
        start      = 1'b1;
        alucontrol = OP_DIV;
        a          = 32'd50;
        b          = 32'd3;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        flush = 1'b1;
        #1;
        check("flush_stall", 32'(stall_o), 32'd0);
        cycle();
        flush = 1'b0;
        #1;
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_hi", hi_o, save_hi);
        check("flush_lo", lo_o, save_lo);
        @(negedge clk);

        // Reset mid-divide.
        start      = 1'b1;
        alucontrol = OP_DIV;
        a          = 32'd50;
        b          = 32'd3;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        resetn = 1'b0;
        #1;
        check("mrst_stall", 32'(stall_o), 32'd0);
        check("mrst_busy", 32'(busy_o), 32'd0);
        check("mrst_hi", hi_o, 32'd0);
        check("mrst_lo", lo_o, 32'd0);
        m_left = 0;
        m_done = 1'b0;
        m_hi   = '0;
        m_lo   = '0;
        @(negedge clk);
        resetn = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            start      = ($urandom_range(0, 1) == 1);
            flush      = ($urandom_range(0, 19) == 0);
            alucontrol = op_pool[$urandom_range(0, 7)];
            a          = rand_val();
            b          = rand_val();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
